prim_fetch: RTL and testbench



---
 rtl/prim_fetch_pkg.sv | 34 +++
 rtl/prim_fetch_if.sv | 29 ++
 rtl/prim_fetch_rec_reg.sv | 33 +++
 rtl/prim_fetch.sv | 189 ++++++++++++++++++
 tb/tb_prim_fetch.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/prim_fetch_pkg.sv
// Shared FSM encoding, record layout and primitive-type constants for prim_fetch.
package prim_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CNT_WAIT = 3'd1,
        ST_CNT_CAP  = 3'd2,
        ST_FETCH    = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_PRESENT  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam int REC_WORDS = 9;

    // Record word numbers; word N arrives on ram_read_dataN.
    localparam int W_TYPE  = 1;
    localparam int W_X0    = 2;
    localparam int W_Y0    = 3;
    localparam int W_X1    = 4;
    localparam int W_Y1    = 5;
    localparam int W_X2    = 6;
    localparam int W_Y2    = 7;
    localparam int W_COLOR = 8;

    localparam logic [31:0] PRIM_LINE = 32'd0;
    localparam logic [31:0] PRIM_TRI  = 32'd1;

    // True when a record starting at base would run past the top of the address space.
    function automatic logic rec_past_end(input int unsigned base, input int unsigned addr_bits);
        return (base + 32'(REC_WORDS) - 32'd1) > ((32'd1 << addr_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/prim_fetch_if.sv
// Primitive valid/ready handshake from the fetcher to the line/triangle rasterizer.
interface prim_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          prim_valid;
    logic          prim_ready;
    logic [DW-1:0] prim_type;
    logic [DW-1:0] prim_x0;
    logic [DW-1:0] prim_y0;
    logic [DW-1:0] prim_x1;
    logic [DW-1:0] prim_y1;
    logic [DW-1:0] prim_x2;
    logic [DW-1:0] prim_y2;
    logic [DW-1:0] prim_color;
    logic [AW-1:0] prim_index;

    modport master (
        output prim_valid, prim_type, prim_x0, prim_y0, prim_x1, prim_y1,
               prim_x2, prim_y2, prim_color, prim_index,
        input  prim_ready
    );

    modport slave (
        input  prim_valid, prim_type, prim_x0, prim_y0, prim_x1, prim_y1,
               prim_x2, prim_y2, prim_color, prim_index,
        output prim_ready
    );
endinterface

// File: rtl/prim_fetch_rec_reg.sv
// Eight-field primitive record register; loads all fields at once and holds otherwise.
module prim_rec_reg #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [8:1][DW-1:0]   fields_in,
    output logic [8:1][DW-1:0]   rec_q
);

    logic [8:1][DW-1:0] rec_d;

    // Next record value: new fields on load, otherwise hold.
    always_comb begin
        rec_d = rec_q;
        if (load_en) begin
            rec_d = fields_in;
        end else begin
            rec_d = rec_q;
        end
    end

    // Record storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

endmodule

// File: rtl/prim_fetch.sv
// Walks the loader-filled vertex RAM and presents one primitive record per handshake.
// Build option PRIM_FETCH_LOOP_EN: restart at record 0 after the last primitive instead of stopping.
module prim_fetch
    import prim_fetch_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 32,
    parameter int MAX_PRIMS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_finish,
    output logic [addr_width-1:0] ram_read_addr,
    input  logic [data_width-1:0] ram_read_data1,
    input  logic [data_width-1:0] ram_read_data2,
    input  logic [data_width-1:0] ram_read_data3,
    input  logic [data_width-1:0] ram_read_data4,
    input  logic [data_width-1:0] ram_read_data5,
    input  logic [data_width-1:0] ram_read_data6,
    input  logic [data_width-1:0] ram_read_data7,
    input  logic [data_width-1:0] ram_read_data8,
    input  logic [data_width-1:0] ram_read_data9,
    prim_fetch_if.master          prim_if,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [data_width-1:0] MAX_WORD = data_width'(MAX_PRIMS);
    localparam logic [addr_width-1:0] MAX_CNT  = addr_width'(MAX_PRIMS);
    localparam logic [addr_width:0]   PTR_FIRST = (addr_width+1)'(1);
    localparam logic [addr_width:0]   PTR_STEP  = (addr_width+1)'(REC_WORDS);

    state_e                  state_q, state_d;
    logic [addr_width:0]     ptr_q, ptr_d;
    logic [addr_width-1:0]   count_q, count_d;
    logic [addr_width-1:0]   index_q, index_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [8:1][data_width-1:0] fields_s;
    logic [8:1][data_width-1:0] rec_s;
    logic                       unused_rsvd_s;

    assign fields_s[W_TYPE]  = ram_read_data1;
    assign fields_s[W_X0]    = ram_read_data2;
    assign fields_s[W_Y0]    = ram_read_data3;
    assign fields_s[W_X1]    = ram_read_data4;
    assign fields_s[W_Y1]    = ram_read_data5;
    assign fields_s[W_X2]    = ram_read_data6;
    assign fields_s[W_Y2]    = ram_read_data7;
    assign fields_s[W_COLOR] = ram_read_data8;
    assign unused_rsvd_s     = ^ram_read_data9;

    prim_rec_reg #(.DW(data_width)) u_rec (
        .clk       (clk),
        .reset     (reset),
        .load_en   (state_q == ST_CAPTURE),
        .fields_in (fields_s),
        .rec_q     (rec_s)
    );

    // Next-state and next-output logic for the fetch pass.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        index_d = index_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start && load_finish) begin
                    state_d = ST_CNT_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT_WAIT: begin
                state_d = ST_CNT_CAP;
            end
            ST_CNT_CAP: begin
                if (ram_read_data1 > MAX_WORD) begin
                    count_d = MAX_CNT;
                    err_d   = 1'b1;
                end else begin
                    count_d = ram_read_data1[addr_width-1:0];
                end
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = PTR_FIRST;
                    index_d = '0;
                    addr_d  = PTR_FIRST[addr_width-1:0];
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rec_past_end(32'(ptr_q), addr_width)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (valid_q && prim_if.prim_ready) begin
                    valid_d = 1'b0;
                    if (index_q == count_q - addr_width'(1)) begin
`ifdef PRIM_FETCH_LOOP_EN
                        ptr_d   = PTR_FIRST;
                        index_d = '0;
                        addr_d  = PTR_FIRST[addr_width-1:0];
                        state_d = ST_FETCH;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        ptr_d   = ptr_q + PTR_STEP;
                        index_d = index_q + addr_width'(1);
                        addr_d  = ptr_d[addr_width-1:0];
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram_read_addr      = addr_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign prim_if.prim_valid = valid_q;
    assign prim_if.prim_index = index_q;
    assign prim_if.prim_type  = rec_s[W_TYPE];
    assign prim_if.prim_x0    = rec_s[W_X0];
    assign prim_if.prim_y0    = rec_s[W_Y0];
    assign prim_if.prim_x1    = rec_s[W_X1];
    assign prim_if.prim_y1    = rec_s[W_Y1];
    assign prim_if.prim_x2    = rec_s[W_X2];
    assign prim_if.prim_y2    = rec_s[W_Y2];
    assign prim_if.prim_color = rec_s[W_COLOR];

endmodule

// File: tb/tb_prim_fetch.sv
// Directed self-checking bench for prim_fetch with a one-cycle-latency RAM model.
module tb_prim_fetch;
    import prim_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_finish = 1'b0;
    logic [7:0]  addr;
    logic [31:0] rd [1:9];
    logic        busy, done, err;
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    prim_fetch_if #(.AW(8), .DW(32)) pif ();

    prim_fetch #(.addr_width(8), .data_width(32), .MAX_PRIMS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .load_finish(load_finish),
        .ram_read_addr(addr),
        .ram_read_data1(rd[1]), .ram_read_data2(rd[2]), .ram_read_data3(rd[3]),
        .ram_read_data4(rd[4]), .ram_read_data5(rd[5]), .ram_read_data6(rd[6]),
        .ram_read_data7(rd[7]), .ram_read_data8(rd[8]), .ram_read_data9(rd[9]),
        .prim_if(pif), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 9; i++) rd[i+1] <= mem[8'(addr + 8'(i))];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_two(input logic [31:0] n);
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = n;
        mem[1] = 32'd1;  mem[2] = 32'd10; mem[3] = 32'd20; mem[4] = 32'd30;  mem[5] = 32'd40;
        mem[6] = 32'd50; mem[7] = 32'd60; mem[8] = 32'hFF; mem[9] = 32'd0;
        mem[10] = 32'd0; mem[11] = 32'd5; mem[12] = 32'd5; mem[13] = 32'd100; mem[14] = 32'd100;
        mem[15] = 32'd0; mem[16] = 32'd0; mem[17] = 32'h0F; mem[18] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; start = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pif.prim_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok, output int nacc);
        ok = 1'b0; nacc = 0;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            if (pif.prim_valid === 1'b1 && pif.prim_ready === 1'b1) nacc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        load_two(32'd2); pif.prim_ready = 1'b0; load_finish = 1'b0;
        do_reset();
        checks++; if (pif.prim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pif.prim_valid); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/err got %b want 000", {busy, done, err}); end
        checks++; if (addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        checks++; if (pif.prim_index !== 8'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", pif.prim_index); end
        checks++; if ({pif.prim_type, pif.prim_x0, pif.prim_y2, pif.prim_color} !== 128'd0) begin errors++; $display("FAIL reset_fields: got nonzero fields"); end
    endtask

    task automatic test_basic();
        bit ok; int s, v, h, nacc;
        load_two(32'd2); pif.prim_ready = 1'b1; load_finish = 1'b1;
        do_reset();
        start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0; load_finish = 1'b0;
        wait_valid(ok); v = cyc;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got timeout want valid"); end
        checks++; if (v - s - 1 !== 4) begin errors++; $display("FAIL basic_start_latency: got %0d setup cycles want 4", v - s - 1); end
        checks++; if (pif.prim_type !== PRIM_TRI) begin errors++; $display("FAIL basic_type0: got %0d want 1", pif.prim_type); end
        checks++; if ({pif.prim_x0, pif.prim_y0, pif.prim_x1, pif.prim_y1} !== {32'd10, 32'd20, 32'd30, 32'd40}) begin errors++; $display("FAIL basic_xy0: got %0d %0d %0d %0d want 10 20 30 40", pif.prim_x0, pif.prim_y0, pif.prim_x1, pif.prim_y1); end
        checks++; if ({pif.prim_x2, pif.prim_y2, pif.prim_color} !== {32'd50, 32'd60, 32'hFF}) begin errors++; $display("FAIL basic_x2y2c0: got %0d %0d %0h want 50 60 ff", pif.prim_x2, pif.prim_y2, pif.prim_color); end
        checks++; if (pif.prim_index !== 8'd0) begin errors++; $display("FAIL basic_index0: got %0d want 0", pif.prim_index); end
        h = cyc;
        @(negedge clk);
        wait_valid(ok); v = cyc;
        checks++; if (ok !== 1'b1 || v - h !== 3) begin errors++; $display("FAIL basic_accept_latency: got %0d cycles (ok=%b) want 3", v - h, ok); end
        checks++; if ({pif.prim_type, pif.prim_x0, pif.prim_x1, pif.prim_color} !== {PRIM_LINE, 32'd5, 32'd100, 32'h0F}) begin errors++; $display("FAIL basic_rec1: got type=%0d x0=%0d x1=%0d c=%0h want 0 5 100 f", pif.prim_type, pif.prim_x0, pif.prim_x1, pif.prim_color); end
        checks++; if (pif.prim_index !== 8'd1) begin errors++; $display("FAIL basic_index1: got %0d want 1", pif.prim_index); end
        wait_done(ok, nacc);
        checks++; if (ok !== 1'b1 || nacc !== 1) begin errors++; $display("FAIL basic_done: ok=%b extra accepts=%0d want ok=1 accepts=1", ok, nacc); end
        checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL basic_err_busy: got %b want 00", {err, busy}); end
    endtask

    task automatic test_backpressure();
        bit ok; int nacc;
        load_two(32'd2); pif.prim_ready = 1'b0; load_finish = 1'b1;
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_valid(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got timeout want valid"); end
        for (int k = 0; k < 5; k++) begin
            checks++; if ({pif.prim_valid, pif.prim_index, pif.prim_x0, pif.prim_color} !== {1'b1, 8'd0, 32'd10, 32'hFF}) begin errors++; $display("FAIL bp_hold_%0d: got v=%b idx=%0d x0=%0d c=%0h want 1 0 10 ff", k, pif.prim_valid, pif.prim_index, pif.prim_x0, pif.prim_color); end
            @(negedge clk);
        end
        pif.prim_ready = 1'b1;
        @(negedge clk);
        checks++; if (pif.prim_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", pif.prim_valid); end
        wait_valid(ok);
        checks++; if (ok !== 1'b1 || pif.prim_index !== 8'd1 || pif.prim_x1 !== 32'd100) begin errors++; $display("FAIL bp_next: ok=%b idx=%0d x1=%0d want 1 1 100", ok, pif.prim_index, pif.prim_x1); end
        wait_done(ok, nacc);
        checks++; if (ok !== 1'b1 || nacc !== 1) begin errors++; $display("FAIL bp_done: ok=%b accepts=%0d want 1 1", ok, nacc); end
    endtask

    task automatic test_zero_count();
        int s, d, nval;
        load_two(32'd0); pif.prim_ready = 1'b1; load_finish = 1'b1;
        do_reset();
        start = 1'b1; s = cyc; nval = 0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pif.prim_valid === 1'b1) nval++;
            if (done === 1'b1) break;
            @(negedge clk);
        end
        d = cyc;
        checks++; if (done !== 1'b1 || d - s !== 3) begin errors++; $display("FAIL zero_done: done=%b at start+%0d want 1 at start+3", done, d - s); end
        checks++; if (nval !== 0 || err !== 1'b0) begin errors++; $display("FAIL zero_quiet: valid cycles=%0d err=%b want 0 0", nval, err); end
    endtask

    task automatic test_clamp();
        bit ok; int nacc;
        load_two(32'd7); pif.prim_ready = 1'b1; load_finish = 1'b1;
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(ok, nacc);
        checks++; if (ok !== 1'b1 || nacc !== 2) begin errors++; $display("FAIL clamp_count: ok=%b accepts=%0d want 1 2", ok, nacc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clamp_err: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        bit ok; int s, v;
        load_two(32'd7); pif.prim_ready = 1'b0; load_finish = 1'b1;
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_valid(ok);
        checks++; if (ok !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL rmid_pre: ok=%b err=%b want 1 1", ok, err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({pif.prim_valid, busy, err, done} !== 4'b0000) begin errors++; $display("FAIL rmid_flags: valid/busy/err/done got %b want 0000", {pif.prim_valid, busy, err, done}); end
        checks++; if (addr !== 8'd0 || pif.prim_index !== 8'd0) begin errors++; $display("FAIL rmid_idle: addr=%0d idx=%0d want 0 0", addr, pif.prim_index); end
        reset = 1'b0; pif.prim_ready = 1'b1;
        start = 1'b1; s = cyc; @(negedge clk); start = 1'b0;
        wait_valid(ok); v = cyc;
        checks++; if (ok !== 1'b1 || v - s !== 5 || pif.prim_index !== 8'd0 || pif.prim_x0 !== 32'd10) begin errors++; $display("FAIL rmid_replay: ok=%b lat=%0d idx=%0d x0=%0d want 1 5 0 10", ok, v - s, pif.prim_index, pif.prim_x0); end
    endtask

    task automatic test_no_load();
        load_two(32'd2); pif.prim_ready = 1'b1; load_finish = 1'b0;
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        start = 1'b0; load_finish = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        checks++; if ({busy, done, pif.prim_valid} !== 3'b000) begin errors++; $display("FAIL noload_idle: busy/done/valid got %b want 000", {busy, done, pif.prim_valid}); end
        checks++; if (addr !== 8'd0) begin errors++; $display("FAIL noload_addr: got %0d want 0", addr); end
    endtask

`ifdef PRIM_FETCH_LOOP_EN
    task automatic test_loop();
        bit ok;
        load_two(32'd2); pif.prim_ready = 1'b1; load_finish = 1'b1;
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wait_valid(ok);
            checks++; if (ok !== 1'b1 || pif.prim_index !== 8'(p % 2)) begin errors++; $display("FAIL loop_index_%0d: ok=%b idx=%0d want 1 %0d", p, ok, pif.prim_index, p % 2); end
            @(negedge clk);
        end
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL loop_flags: done/busy got %b want 01", {done, busy}); end
    endtask
`endif

    initial begin
        pif.prim_ready = 1'b0;
        for (int i = 1; i <= 9; i++) rd[i] = 32'd0;
        test_reset();
        test_no_load();
`ifdef PRIM_FETCH_LOOP_EN
        test_loop();
`else
        test_basic();
        test_backpressure();
        test_zero_count();
        test_clamp();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
